// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Multi-cycle instruction sequencer between the instruction decoder and the
//   datapath. Each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> WB.
//   Outputs depend only on the state register and the latched control fields.
//   Free-run when run=1; otherwise one instruction per rising edge of step.
//
// Ports
//   clock             system clock, rising edge
//   reset             synchronous, active-high
//   run               1 = free-run, 0 = single-step
//   step              raw single-step level, rising edge detected internally
//   imem_ack          instruction word valid this cycle
//   dmem_ack          data memory/stack access complete this cycle
//   dec_pc_increment  1 = PC+1, 0 = PC load (branch)
//   dec_load_src      0 self, 1 alu, 2 mem, 3 stk
//   dec_store_to_mem  store reg[C] to mem[ALU]
//   dec_store_to_stk  store reg[C] to stk[ALU]
//   state             0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB
//   imem_req          instruction fetch request (FETCH)
//   ir_load           instruction-register load strobe (DECODE)
//   dmem_req          data access request (MEM)
//   dmem_we           data access is a write
//   dmem_stk          data access targets the stack
//   reg_write         register-file write strobe (WB)
//   pc_step           PC increment strobe (WB)
//   pc_jump           PC load strobe (WB)
//   retired           retired-instruction count, wraps at 16 bits
module exec_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        dec_pc_increment,
  input  logic [1:0]  dec_load_src,
  input  logic        dec_store_to_mem,
  input  logic        dec_store_to_stk,
  output logic [2:0]  state,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        dmem_stk,
  output logic        reg_write,
  output logic        pc_step,
  output logic        pc_jump,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t      state_q;
  logic        step_q;
  logic [1:0]  load_src_q;
  logic        store_mem_q;
  logic        store_stk_q;
  logic        pc_inc_q;
  logic [15:0] retired_q;

  logic step_rise;
  logic needs_mem;

  assign step_rise = step & ~step_q;
  // Evaluated on the same decoder values that are latched at the end of EXEC,
  // so the branch to MEM agrees with the latched control fields.
  assign needs_mem = dec_load_src[1] | dec_store_to_mem | dec_store_to_stk;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= 1'b0;
      load_src_q  <= '0;
      store_mem_q <= 1'b0;
      store_stk_q <= 1'b0;
      pc_inc_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      step_q <= step;
      case (state_q)
        S_IDLE:   if (run || step_rise) state_q <= S_FETCH;
        S_FETCH:  if (imem_ack) state_q <= S_DECODE;
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          load_src_q  <= dec_load_src;
          store_mem_q <= dec_store_to_mem;
          store_stk_q <= dec_store_to_stk;
          pc_inc_q    <= dec_pc_increment;
          state_q     <= needs_mem ? S_MEM : S_WB;
        end
        S_MEM:    if (dmem_ack) state_q <= S_WB;
        S_WB: begin
          retired_q <= retired_q + 16'd1;
          state_q   <= run ? S_FETCH : S_IDLE;
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state_q == S_FETCH);
    ir_load   = (state_q == S_DECODE);
    dmem_req  = (state_q == S_MEM);
    dmem_we   = (state_q == S_MEM) & (store_mem_q | store_stk_q);
    // Stack wins when both store bits are set.
    dmem_stk  = (state_q == S_MEM) & (store_stk_q | (load_src_q == 2'd3));
    reg_write = (state_q == S_WB) & (load_src_q != 2'd0);
    pc_step   = (state_q == S_WB) & pc_inc_q;
    pc_jump   = (state_q == S_WB) & ~pc_inc_q;
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  logic        clock = 1'b0;
  logic        reset, run, step, imem_ack, dmem_ack, dec_pc_increment;
  logic [1:0]  dec_load_src;
  logic        dec_store_to_mem, dec_store_to_stk;
  logic [2:0]  state;
  logic        imem_req, ir_load, dmem_req, dmem_we, dmem_stk;
  logic        reg_write, pc_step, pc_jump;
  logic [15:0] retired;

  exec_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .dec_pc_increment(dec_pc_increment), .dec_load_src(dec_load_src),
    .dec_store_to_mem(dec_store_to_mem), .dec_store_to_stk(dec_store_to_stk),
    .state(state), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_stk(dmem_stk),
    .reg_write(reg_write), .pc_step(pc_step), .pc_jump(pc_jump),
    .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        we;
    bit        stk;
    bit        rw;
    bit        ps;
    bit        pj;
    int        lat;
    int        memc;
    bit [15:0] ret;
  } exp_t;

  exp_t      exp_q[$];
  int        n_pass = 0;
  int        n_total = 0;
  bit        mon_en = 1'b0;
  bit [15:0] exp_retired = '0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (state !== s && n < 100) begin
      tick();
      n++;
    end
    if (state !== s) chk("wait_state_timeout", int'(state), int'(s));
  endtask

  // Expected behaviour is derived from the instruction's meaning: a memory
  // phase exists for any load from mem/stk or any store; each ack delay adds
  // one cycle to the 4-cycle base.
  task automatic do_instr(input logic [1:0] ls, input bit sm, input bit ss,
                          input bit pi, input int di, input int dd);
    exp_t e;
    bit   has_mem;
    dec_load_src = ls; dec_store_to_mem = sm; dec_store_to_stk = ss;
    dec_pc_increment = pi;
    has_mem = (ls == 2 || ls == 3 || sm || ss);
    e.we   = sm || ss;
    e.stk  = ss || (ls == 3);
    e.rw   = (ls != 0);
    e.ps   = pi;
    e.pj   = !pi;
    e.memc = has_mem ? 1 + dd : 0;
    e.lat  = 4 + di + e.memc;
    e.ret  = exp_retired;
    exp_q.push_back(e);
    exp_retired = exp_retired + 16'd1;
    wait_state(3'd1);
    repeat (di) tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();  // EXEC
    tick();  // MEM or WB: decoder values must now be ignored
    dec_load_src = 2'($urandom_range(0, 3));
    dec_store_to_mem = 1'($urandom_range(0, 1));
    dec_store_to_stk = 1'($urandom_range(0, 1));
    dec_pc_increment = 1'($urandom_range(0, 1));
    if (has_mem) begin
      repeat (dd) tick();
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
    end
    tick();  // leaves WB
  endtask

  // Monitor: tracks each instruction from FETCH entry and compares on WB.
  initial begin
    logic [2:0] prev = 3'd0;
    int         cyc = 0, memc = 0, irl = 0;
    bit         run_at_wb = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (prev == 3'd5) chk("after_wb_state", int'(state), run_at_wb ? 1 : 0);
        if (state == 3'd1 && prev != 3'd1) begin
          cyc = 0; memc = 0; irl = 0;
        end
        cyc++;
        if (ir_load) irl++;
        if (state == 3'd1) chk("imem_req", int'(imem_req), 1);
        if (state == 3'd4) begin
          memc++;
          if (exp_q.size() == 0) chk("mem_without_instr", 0, 1);
          else begin
            e = exp_q[0];
            chk("dmem_req", int'(dmem_req), 1);
            chk("dmem_we", int'(dmem_we), int'(e.we));
            chk("dmem_stk", int'(dmem_stk), int'(e.stk));
          end
        end else if (dmem_req) chk("stray_dmem_req", 1, 0);
        if (state == 3'd5) begin
          run_at_wb = run;
          if (exp_q.size() == 0) chk("wb_without_instr", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("reg_write", int'(reg_write), int'(e.rw));
            chk("pc_step", int'(pc_step), int'(e.ps));
            chk("pc_jump", int'(pc_jump), int'(e.pj));
            chk("retired_at_wb", int'(retired), int'(e.ret));
            chk("latency", cyc, e.lat);
            chk("mem_cycles", memc, e.memc);
            chk("ir_load_count", irl, 1);
          end
        end else if (reg_write || pc_step || pc_jump) chk("stray_strobe", 1, 0);
      end
      prev = state;
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_pc_increment = 1'b0; dec_load_src = '0;
    dec_store_to_mem = 1'b0; dec_store_to_stk = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_reqs", int'({imem_req, ir_load, dmem_req, dmem_we, dmem_stk}), 0);
    chk("rst_strobes", int'({reg_write, pc_step, pc_jump}), 0);
    chk("rst_retired", int'(retired), 0);
    mon_en = 1'b1;
    repeat (3) tick();
    chk("idle_hold", int'(state), 0);

    // Free-run: directed cases then random ones
    run = 1'b1;
    do_instr(2'd1, 1'b0, 1'b0, 1'b1, 0, 0);   // ALU op, 4 cycles
    chk("retired_after_first", int'(retired), 1);
    do_instr(2'd3, 1'b0, 1'b0, 1'b1, 0, 3);   // stack load, 8 cycles
    do_instr(2'd0, 1'b1, 1'b0, 1'b0, 0, 0);   // branch + store to mem
    do_instr(2'd0, 1'b1, 1'b1, 1'b1, 1, 1);   // both stores: stack wins
    for (int i = 0; i < 40; i++)
      do_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    run = 1'b0;  // dropped mid-instruction: finishes then stops
    do_instr(2'd2, 1'b0, 1'b0, 1'b1, 2, 1);
    repeat (3) tick();
    chk("run_drop_idle", int'(state), 0);

    // Step held high: exactly one instruction
    step = 1'b1;
    tick();
    chk("step_start_fetch", int'(state), 1);
    do_instr(2'd1, 1'b0, 1'b0, 1'b1, 0, 0);
    repeat (15) tick();
    chk("step_held_idle", int'(state), 0);
    chk("step_held_retired", int'(retired), int'(exp_retired));
    step = 1'b0;
    tick();

    // Second rise during execution is discarded
    step = 1'b1;
    fork
      do_instr(2'd2, 1'b0, 1'b0, 1'b0, 5, 0);
      begin
        tick(); step = 1'b0;
        tick(); step = 1'b1;
        tick(); step = 1'b0;
      end
    join
    repeat (8) tick();
    chk("step_pulse_idle", int'(state), 0);
    chk("step_pulse_retired", int'(retired), int'(exp_retired));

    // Counter wrap
    force dut.retired_q = 16'hFFFF;
    tick();
    release dut.retired_q;
    exp_retired = 16'hFFFF;
    step = 1'b1;
    fork
      do_instr(2'd1, 1'b0, 1'b0, 1'b1, 0, 0);
      begin tick(); step = 1'b0; end
    join
    chk("retired_wrap", int'(retired), 0);
    exp_retired = 16'd0;

    // Reset in MEM together with dmem_ack
    tick();
    dec_load_src = 2'd2; dec_store_to_mem = 1'b0; dec_store_to_stk = 1'b0;
    dec_pc_increment = 1'b1;
    begin
      exp_t e;
      e.we = 1'b0; e.stk = 1'b0; e.rw = 1'b1; e.ps = 1'b1; e.pj = 1'b0;
      e.lat = 5; e.memc = 1; e.ret = exp_retired;
      exp_q.push_back(e);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_state(3'd1);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    wait_state(3'd4);
    dmem_ack = 1'b1;
    reset = 1'b1;
    tick();
    dmem_ack = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    chk("abort_state", int'(state), 0);
    chk("abort_dmem_req", int'(dmem_req), 0);
    chk("abort_strobes", int'({reg_write, pc_step, pc_jump}), 0);
    chk("abort_retired", int'(retired), 0);
    repeat (4) tick();
    chk("abort_idle", int'(state), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle instruction sequencer sitting between the instruction decoder and the datapath. It steps each instruction through fetch, decode, execute, optional memory/stack access, and writeback. It issues one-cycle strobes for instruction-register load, register-file write, memory/stack write and program-counter update. It supports free-run and single-step execution (step source: the user clock button) and counts retired instructions.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `run`  in  1  level; 1 = free-run, 0 = single-step
- `step`  in  1  raw single-step level (user clock), rising-edge detected internally
- `imem_ack`  in  1  instruction word valid this cycle
- `dmem_ack`  in  1  data memory/stack access complete this cycle
- `dec_pc_increment`  in  1  decoder: 1 = PC+1, 0 = PC load (branch)
- `dec_load_src`  in  2  decoder: 0 self, 1 alu, 2 mem, 3 stk
- `dec_store_to_mem`  in  1  decoder: store reg[C] to mem[ALU]
- `dec_store_to_stk`  in  1  decoder: store reg[C] to stk[ALU]
- `state`  out  3  0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB
- `imem_req`  out  1  instruction fetch request
- `ir_load`  out  1  latch instruction register
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  data access is a write
- `dmem_stk`  out  1  data access targets stack (0 = memory)
- `reg_write`  out  1  register-file write strobe
- `pc_step`  out  1  PC increment strobe
- `pc_jump`  out  1  PC load strobe
- `retired`  out  16  retired-instruction count

## Operation
- Outputs are decoded from the state register and the latched control fields only. There is no combinational path from inputs to outputs.
- Step edge detect: the `step` input is registered to `step_q`; `step_rise = step & ~step_q`.
- IDLE: go to FETCH if `run` or `step_rise`; otherwise stay.
- FETCH: `imem_req`=1. Go to DECODE in the cycle `imem_ack`=1; hold otherwise, with no timeout.
- DECODE: `ir_load`=1 for exactly one cycle, then EXEC.
- EXEC: at the end of this cycle, latch `dec_load_src`, `dec_store_to_mem`, `dec_store_to_stk` and `dec_pc_increment` into control registers. Decoder input changes after EXEC are ignored.
  - Go to MEM if latched load_src ∈ {2,3} or either store bit is set.
  - Otherwise go to WB.
- MEM: `dmem_req`=1.
  - `dmem_we` = store_to_mem | store_to_stk.
  - `dmem_stk` = store_to_stk | (load_src==3).
  - Go to WB when `dmem_ack`=1; hold otherwise.
  - If both store bits are set, the stack store wins: `dmem_stk`=1.
- WB: one cycle.
  - `reg_write` = (load_src != 0).
  - `pc_step` = pc_increment; `pc_jump` = ~pc_increment. Exactly one of the two is high.
  - `retired` increments by 1, wrapping 0xFFFF→0x0000.
  - Next state: FETCH if `run`=1, else IDLE.
- A `step_rise` outside IDLE is discarded. It does not queue.
- Dropping `run` mid-instruction completes the current instruction, then stops in IDLE.

## Timing
- Reset values (cycle after `reset` sampled high): `state`=IDLE, every strobe and request output 0, `retired`=0, control registers 0, `step_q`=0.
- Reset mid-instruction aborts the instruction immediately. No WB strobes are emitted and pending requests drop the next cycle.
- `reset` overrides all other inputs, including a simultaneous ack.
- Latency, ALU-only instruction with ack in the first FETCH cycle: 4 cycles (FETCH, DECODE, EXEC, WB).
- Latency, memory instruction with both acks immediate: 5 cycles.
- Each cycle of ack delay adds one cycle.
- Free-run throughput: WB is followed directly by FETCH, with no IDLE bubble.
- Step mode: from `step_rise` in IDLE, FETCH starts the next cycle and exactly one instruction executes.
- All strobes (`ir_load`, `reg_write`, `pc_step`, `pc_jump`) are single-cycle per instruction.
- `imem_req`/`dmem_req` stay high continuously until acknowledged. Acks seen outside FETCH/MEM are ignored.

## Test plan
- Reset, then `run`=1, ALU op (load_src=1, pc_increment=1), `imem_ack` tied 1 -> states 1,2,3,5,1…; `reg_write`=`pc_step`=1 in cycle 4; `retired`=1 after the first WB.
- Load from stack (load_src=3), `dmem_ack` delayed 3 cycles -> `dmem_req`=1, `dmem_stk`=1, `dmem_we`=0 for 4 cycles; WB `reg_write`=1; 8 cycles total.
- Branch with store_to_mem=1, load_src=0 -> MEM with `dmem_we`=1, `dmem_stk`=0; WB `reg_write`=0, `pc_jump`=1, `pc_step`=0.
- `run`=0, `step` held high 20 cycles then pulsed twice -> exactly one instruction per rising edge; a held level executes once; a second rise during execution is ignored.
- Preload `retired` to 0xFFFF via 65535 steps (or a force), execute one instruction -> `retired`=0x0000.
- `reset` asserted in MEM with `dmem_ack`=1 the same cycle -> next cycle `state`=0, `dmem_req`=0, no `reg_write` or PC strobe, `retired` unchanged at 0.
